up_down_counter_seq: RTL and testbench
======================================

Name: up_down_counter_seq

Overview:
- Command sequencer for the 4-bit up/down counter (load/updown/data in, count out).
- Accepts queued-style commands over a valid/ready handshake: LOAD, step UP n, step DOWN n, SEEK target.
- Drives the counter's control pins and watches its count.
- When idle, it freezes the counter by self-reloading it every cycle, because the counter has no enable.

Parameters:
- WIDTH, 4: counter/data width; also the argument width.
- OP_W, 2: opcode width. Fixed encoding; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  command present
- cmd_op  in  OP_W  00=LOAD, 01=UP, 10=DOWN, 11=SEEK
- cmd_arg  in  WIDTH  load value / step count / seek target
- cmd_ready  out  1  sequencer can accept a command
- abort  in  1  synchronous cancel of the executing command
- cnt_count  in  WIDTH  current counter value
- cnt_load  out  1  to counter load
- cnt_updown  out  1  to counter updown; 1=up, 0=down
- cnt_data  out  WIDTH  to counter data
- busy  out  1  command executing
- done  out  1  one-cycle pulse: command completed normally
- aborted  out  1  one-cycle pulse: command cancelled

Behaviour:
- FSM states: IDLE, EXEC.
- Registers: state, op_q, arg_q, remaining (WIDTH bits), done, aborted.
- All other outputs are Moore-decoded from these registers.
- Reset (rst=0, async) values:
  - state=IDLE, op_q=0, arg_q=0, remaining=0, done=0, aborted=0.
  - Decoded outputs during reset: busy=0, cmd_ready=1, cnt_load=1, cnt_data=cnt_count, cnt_updown=0.
  - Nothing is accepted while rst=0.
- IDLE:
  - Outputs: cmd_ready=1, busy=0, cnt_load=1, cnt_data=cnt_count, cnt_updown=0. The counter holds its value.
  - Accept on the rising edge where cmd_valid=1 in IDLE. Capture op and arg, set remaining=cmd_arg, go to EXEC.
  - No accept is possible in EXEC; cmd_ready=0 there.
- EXEC, LOAD:
  - Outputs for exactly 1 cycle: cnt_load=1, cnt_data=arg_q.
  - At the next edge the counter takes arg_q, the FSM goes to IDLE and done=1 for that cycle.
- EXEC, UP/DOWN:
  - Outputs: cnt_load=0; cnt_updown=1 (UP) or 0 (DOWN).
  - remaining decrements each edge. When remaining==1 at an edge, go to IDLE with done=1.
  - Net result: the count changes by exactly arg, modulo 2^WIDTH (wraps 15->0 and 0->15).
  - arg=0: EXEC lasts 1 cycle with hold outputs (cnt_load=1, cnt_data=cnt_count), then done. Count is unchanged.
- EXEC, SEEK:
  - Every cycle compare cnt_count to arg_q.
  - Not equal: cnt_load=0, cnt_updown=1 (count up).
  - Equal: hold outputs, go to IDLE with done=1.
  - Worst case is 15 steps plus 1 hold cycle, because wrap guarantees a hit.
  - Target already equal on entry: 1 cycle, count unchanged.
- done and aborted are registered and asserted in the first IDLE cycle. They are never both 1.
- abort:
  - Sampled only in EXEC. At that edge, go to IDLE, aborted=1, done=0.
  - The counter keeps the value it reached at that edge.
  - Ignored in IDLE.
  - If abort coincides with the completing edge, abort wins: aborted=1, done=0.
- Back-to-back: a command may be accepted in the same cycle that done/aborted is high, since that is an IDLE cycle.
- Reset mid-command: the sequencer returns to IDLE immediately, outputs go to their reset values, and the command is lost with no pulse.
- The counter's own reset is handled by integration; the sequencer does not drive it.
- cnt_count is a registered counter output, so decoding outputs from it causes no combinational loop.

Decomposition:
- Shared package:
  - Opcode constants OP_LOAD, OP_UP, OP_DOWN, OP_SEEK.
  - State encodings S_IDLE, S_EXEC.
  - Width constant CNT_W=4.
- Natural sub-module: up_down_counter, instantiated alongside this block in a wrapper up_down_counter_sys. The sequencer RTL itself is flat.

Test Plan:
- Reset, then idle 10 cycles with count preloaded to 7 -> count stays 7, cmd_ready=1, busy=0, no pulses.
- LOAD 10, then UP 3 -> count=10 one edge after LOAD exec; 13 three edges later; done pulses once per command.
- LOAD 14, then UP 4 -> count sequence 15,0,1,2 (wrap); then DOWN 3 -> 1,0,15; final done with count=15.
- LOAD 2, then SEEK 9 -> 7 up-steps, count=9, done; then SEEK 9 again -> 1 cycle, count stays 9, done.
- LOAD 8, UP 10, abort asserted in the 4th EXEC cycle -> count=12 held, aborted=1, done=0; next LOAD 0 is accepted in that pulse cycle.
- UP 0 -> 1 EXEC cycle, count unchanged, done. Also: rst=0 mid-DOWN 5 -> busy=0 immediately, no done/aborted.

Source files
------------

// File: rtl/up_down_counter_seq_pkg.sv
// Shared constants for the up/down counter command sequencer.
// Holds the opcode encoding, the FSM state type and the counter width.
package up_down_counter_seq_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/up_down_counter_seq.sv
// Command sequencer that drives a 4-bit up/down counter through LOAD, UP n, DOWN n and SEEK.
// While idle it reloads the counter with its own value every cycle, because the counter has no enable.
module up_down_counter_seq
  import up_down_counter_seq_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int OP_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             cmd_ready,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_count,
  output logic             cnt_load,
  output logic             cnt_updown,
  output logic [WIDTH-1:0] cnt_data,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  state_t           state, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] remaining, remaining_d;
  logic             done_d, aborted_d;
  logic             finish;
  logic             seek_hit;
  logic             steps_left;

  assign seek_hit   = (cnt_count == arg_q);
  assign steps_left = (remaining != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      arg_q     <= '0;
      remaining <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      remaining <= remaining_d;
      done      <= done_d;
      aborted   <= aborted_d;
    end
  end

  // A step command with zero remaining finishes on its single hold cycle.
  always_comb begin
    finish = 1'b0;
    case (op_q)
      OP_LOAD: finish = 1'b1;
      OP_UP,
      OP_DOWN: finish = (remaining <= 1);
      OP_SEEK: finish = seek_hit;
      default: finish = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state;
    op_d        = op_q;
    arg_d       = arg_q;
    remaining_d = remaining;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d     = S_EXEC;
          op_d        = cmd_op;
          arg_d       = cmd_arg;
          remaining_d = cmd_arg;
        end
      end
      S_EXEC: begin
        if (steps_left) remaining_d = remaining - 1'b1;
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (finish) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registers and the registered counter value.
  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    cnt_load   = 1'b1;
    cnt_updown = 1'b0;
    cnt_data   = cnt_count;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_EXEC: begin
        busy = 1'b1;
        case (op_q)
          OP_LOAD: cnt_data = arg_q;
          OP_UP: begin
            if (steps_left) begin
              cnt_load   = 1'b0;
              cnt_updown = 1'b1;
            end
          end
          OP_DOWN: begin
            if (steps_left) cnt_load = 1'b0;
          end
          OP_SEEK: begin
            if (!seek_hit) begin
              cnt_load   = 1'b0;
              cnt_updown = 1'b1;
            end
          end
          default: cnt_data = cnt_count;
        endcase
      end
      default: cmd_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_up_down_counter_seq.sv
// Randomized bench for up_down_counter_seq with a behavioural counter attached.
// Expected counts come from command-level arithmetic, not from the sequencer's cycle behaviour.
module tb_up_down_counter_seq;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b10;
  localparam logic [1:0] SEEK = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       cmd_ready;
  logic       abort;
  logic [3:0] cnt;
  logic       cnt_load;
  logic       cnt_updown;
  logic [3:0] cnt_data;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       preload_en;
  logic [3:0] preload_val;

  int check_count = 0;
  int pass_count  = 0;
  int model_count;

  always #5 clk = ~clk;

  up_down_counter_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .cnt_count  (cnt),
    .cnt_load   (cnt_load),
    .cnt_updown (cnt_updown),
    .cnt_data   (cnt_data),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  // Stand-in for the real counter: load wins, otherwise step each edge.
  always_ff @(posedge clk) begin
    if (preload_en)    cnt <= preload_val;
    else if (cnt_load) cnt <= cnt_data;
    else if (cnt_updown) cnt <= cnt + 4'd1;
    else               cnt <= cnt - 4'd1;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    else
      pass_count++;
  endtask

  function automatic int exp_cycles(input logic [1:0] op, input int arg, input int start);
    case (op)
      LOAD:    return 1;
      UP, DOWN: return (arg == 0) ? 1 : arg;
      default: return ((arg - start) & 15) + 1;
    endcase
  endfunction

  function automatic int exp_count(input logic [1:0] op, input int arg, input int start, input int edges);
    int steps;
    case (op)
      LOAD: return arg;
      UP: begin
        steps = (arg == 0) ? 0 : edges;
        return (start + steps) & 15;
      end
      DOWN: begin
        steps = (arg == 0) ? 0 : edges;
        return (start - steps) & 15;
      end
      default: begin
        steps = (arg - start) & 15;
        if (edges < steps) steps = edges;
        return (start + steps) & 15;
      end
    endcase
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_value("idle_count", cnt, model_count);
      check_value("idle_ready", cmd_ready, 1);
      check_value("idle_busy", busy, 0);
      check_value("idle_pulses", {done, aborted}, 0);
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the pulse cycle.
  task automatic apply_stimulus(input logic [1:0] op, input int arg, input int abort_at);
    int start, ecyc, cycles, edges;
    start = model_count;
    ecyc  = exp_cycles(op, arg, start);
    check_value("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg[3:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      check_value("exec_ready", cmd_ready, 0);
      abort = (cycles == abort_at);
      @(negedge clk);
      abort = 1'b0;
    end
    edges = (abort_at != 0) ? abort_at : ecyc;
    check_value("exec_cycles", cycles, edges);
    check_value("done", done, abort_at == 0);
    check_value("aborted", aborted, abort_at != 0);
    model_count = exp_count(op, arg, start, edges);
    check_value("final_count", cnt, model_count);
  endtask

  initial begin
    int start, op, arg, abort_at, ecyc;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = LOAD;
    cmd_arg = '0;
    abort = 1'b0;
    preload_en = 1'b1;
    preload_val = 4'd7;
    @(negedge clk);
    @(negedge clk);
    preload_en = 1'b0;
    check_value("rst_busy", busy, 0);
    check_value("rst_ready", cmd_ready, 1);
    check_value("rst_load", cnt_load, 1);
    check_value("rst_updown", cnt_updown, 0);
    check_value("rst_data", cnt_data, 7);
    check_value("rst_pulses", {done, aborted}, 0);
    cmd_valid = 1'b1;
    @(negedge clk);
    check_value("rst_no_accept", busy, 0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    model_count = 7;
    idle_cycles(10);

    apply_stimulus(LOAD, 10, 0);
    apply_stimulus(UP, 3, 0);
    apply_stimulus(LOAD, 14, 0);
    apply_stimulus(UP, 4, 0);
    apply_stimulus(DOWN, 3, 0);
    apply_stimulus(LOAD, 2, 0);
    apply_stimulus(SEEK, 9, 0);
    apply_stimulus(SEEK, 9, 0);
    apply_stimulus(LOAD, 8, 0);
    apply_stimulus(UP, 10, 4);
    apply_stimulus(LOAD, 0, 0);
    apply_stimulus(UP, 0, 0);
    apply_stimulus(SEEK, 15, 0);
    idle_cycles(2);

    start = model_count;
    cmd_valid = 1'b1;
    cmd_op = DOWN;
    cmd_arg = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("midrst_busy", busy, 0);
    check_value("midrst_ready", cmd_ready, 1);
    check_value("midrst_load", cnt_load, 1);
    check_value("midrst_pulses", {done, aborted}, 0);
    @(negedge clk);
    @(negedge clk);
    model_count = (start - 1) & 15;
    check_value("midrst_count", cnt, model_count);
    rst = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 24; i++) begin
      op  = $urandom_range(3, 0);
      arg = $urandom_range(15, 0);
      ecyc = exp_cycles(op[1:0], arg, model_count);
      abort_at = ($urandom_range(3, 0) == 0) ? $urandom_range(ecyc, 1) : 0;
      apply_stimulus(op[1:0], arg, abort_at);
      if ($urandom_range(1, 0) == 1) idle_cycles($urandom_range(2, 1));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
